// File: rtl/pipeline_shift_controller_pkg.sv
// Shared definitions for the pipeline shift controller: controller state
// encoding and a constant-foldable ceiling-log2 helper for counter widths.
package pipeline_shift_controller_pkg;

  typedef enum logic [1:0] {
    ST_FLUSH   = 2'd0,
    ST_RUN     = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DRAINED = 2'd3
  } ctrl_state_e;

  // Smallest width w such that 2**w >= value.
  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width = width + 1;
    return width;
  endfunction

endpackage

// File: rtl/pipeline_shift_controller_if.sv
// Control/handshake bundle between the pipeline shift controller and its
// environment (upstream producer, downstream consumer, datapath controls).
//
// Handshake semantics: a word moves on a side only in a cycle where both its
// valid and its ready are high at the rising clock edge. input_valid must not
// depend on input_ready; output_ready may be driven freely. A word offered
// with input_valid while input_ready is low is simply not taken that cycle.
interface pipeline_shift_controller_if
  import pipeline_shift_controller_pkg::*;
#(
  parameter int PIPE_DEPTH = 4
);

  localparam int COUNT_WIDTH = clog2(PIPE_DEPTH + 1);

  logic                   input_valid;
  logic                   input_ready;
  logic                   output_valid;
  logic                   output_ready;
  logic                   flush;
  logic                   drain_request;
  logic                   drained;
  logic                   pipe_clock_enable;
  logic                   pipe_clear;
  logic [COUNT_WIDTH-1:0] occupancy;
  logic                   busy;
  ctrl_state_e            state;

  // Environment side: drives requests, observes controller outputs.
  modport master (
    output input_valid, output_ready, flush, drain_request,
    input  input_ready, output_valid, drained, pipe_clock_enable,
    input  pipe_clear, occupancy, busy, state
  );

  // Controller side.
  modport slave (
    input  input_valid, output_ready, flush, drain_request,
    output input_ready, output_valid, drained, pipe_clock_enable,
    output pipe_clear, occupancy, busy, state
  );

endinterface

// File: rtl/pipeline_valid_tracker.sv
// Valid-bit shadow of the controlled datapath: one bit per stage, shifted
// with the datapath's clock enable and zeroed with its clear.
module pipeline_valid_tracker #(
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable_i,
  input  logic clear_i,
  input  logic in_i,
  output logic last_o
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;

  // Next shift value: new bit enters at stage 0, others move one stage on.
  generate
    if (DEPTH == 1) begin : g_single
      always_comb valid_d = in_i;
    end else begin : g_multi
      always_comb valid_d = {valid_q[DEPTH-2:0], in_i};
    end
  endgenerate

  // Shift register; clear wins over enable, reset is asynchronous.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (clear_i) begin
      valid_q <= '0;
    end else if (enable_i) begin
      valid_q <= valid_d;
    end
  end

  assign last_o = valid_q[DEPTH-1];

endmodule

// File: rtl/pipeline_shift_controller.sv
// Valid/ready flow controller for a fixed-depth register pipeline. Produces
// the datapath clock enable and clear, tracks stage validity and occupancy,
// and sequences flush and drain requests. Data words never pass through here.
module pipeline_shift_controller
  import pipeline_shift_controller_pkg::*;
#(
  parameter int PIPE_DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  pipeline_shift_controller_if.slave   bus
);

  localparam int COUNT_WIDTH = clog2(PIPE_DEPTH + 1);

  generate
    if (PIPE_DEPTH < 1) begin : g_bad_depth
      $error("pipeline_shift_controller: PIPE_DEPTH must be at least 1");
    end
  endgenerate

  ctrl_state_e            state_q;
  logic [COUNT_WIDTH-1:0] occupancy_q;
  logic [COUNT_WIDTH-1:0] occupancy_d;
  logic                   last_valid;
  logic                   shifting_state;
  logic                   clock_enable;
  logic                   ready;
  logic                   out_valid;
  logic                   accept;
  logic                   deliver;

  // Stall and handshake decode. The whole pipe advances only when the last
  // stage is empty or being consumed, so bubbles are never collapsed.
  always_comb begin
    shifting_state = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    clock_enable   = shifting_state && !bus.flush && (!last_valid || bus.output_ready);
    ready          = clock_enable && (state_q == ST_RUN) && !bus.drain_request;
    out_valid      = last_valid && !bus.flush && (state_q != ST_FLUSH);
    accept         = ready && bus.input_valid;
    deliver        = out_valid && bus.output_ready;
  end

  // Occupancy next value: +1 per accepted word, -1 per delivered word.
  always_comb begin
    occupancy_d = occupancy_q;
    if (accept && !deliver) begin
      occupancy_d = occupancy_q + 1'b1;
    end else if (!accept && deliver) begin
      occupancy_d = occupancy_q - 1'b1;
    end
  end

  // Controller FSM together with the occupancy counter it gates on.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_FLUSH;
      occupancy_q <= '0;
    end else begin
      case (state_q)
        ST_FLUSH: begin
          occupancy_q <= '0;
          state_q     <= ST_RUN;
        end
        ST_RUN: begin
          occupancy_q <= occupancy_d;
          if (bus.flush) begin
            state_q <= ST_FLUSH;
          end else if (bus.drain_request) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          occupancy_q <= occupancy_d;
          if (bus.flush) begin
            state_q <= ST_FLUSH;
          end else if (occupancy_q == '0) begin
            state_q <= ST_DRAINED;
          end
        end
        ST_DRAINED: begin
          if (bus.flush) begin
            state_q <= ST_FLUSH;
          end else if (!bus.drain_request) begin
            state_q <= ST_RUN;
          end
        end
        default: begin
          state_q <= ST_FLUSH;
        end
      endcase
    end
  end

  pipeline_valid_tracker #(
    .DEPTH (PIPE_DEPTH)
  ) u_valid_tracker (
    .clock    (clock),
    .reset_n  (reset_n),
    .enable_i (clock_enable),
    .clear_i  (state_q == ST_FLUSH),
    .in_i     (accept),
    .last_o   (last_valid)
  );

  assign bus.pipe_clock_enable = clock_enable;
  assign bus.pipe_clear        = (state_q == ST_FLUSH);
  assign bus.input_ready       = ready;
  assign bus.output_valid      = out_valid;
  assign bus.drained           = (state_q == ST_DRAINED);
  assign bus.occupancy         = occupancy_q;
  assign bus.busy              = (occupancy_q != '0) || (state_q != ST_RUN);
  assign bus.state             = state_q;

endmodule

// File: tb/tb_pipeline_shift_controller.sv
// Bench for pipeline_shift_controller: directed scenarios with literal
// expectations plus a per-cycle comparison against a word-level model.
module tb_pipeline_shift_controller;
  import pipeline_shift_controller_pkg::*;

  localparam int D  = 4;
  localparam int CW = clog2(D + 1);

  localparam int M_FLUSH   = 0;
  localparam int M_RUN     = 1;
  localparam int M_DRAIN   = 2;
  localparam int M_DRAINED = 3;

  // ---------------- clock / reset ----------------
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  pipeline_shift_controller_if #(.PIPE_DEPTH(D)) bus ();

  pipeline_shift_controller #(.PIPE_DEPTH(D)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- counters / check ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit iv, input bit orr, input bit fl, input bit dr);
    bus.input_valid   = iv;
    bus.output_ready  = orr;
    bus.flush         = fl;
    bus.drain_request = dr;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- word-level model / scoreboard ----------------
  // tag[i] is the id of the word in stage i (0 = bubble); exp_q holds ids
  // accepted and not yet delivered, so its size is the expected occupancy.
  int          m_mode = M_FLUSH;
  int          tag[D];
  int          next_id = 1;
  logic [15:0] exp_q[$];

  bit e_ce, e_ir, e_ov, e_clr, e_drn, e_busy, in_hs, out_hs;
  int e_occ, nxt_mode;

  task automatic model_reset();
    m_mode = M_FLUSH;
    for (int i = 0; i < D; i++) tag[i] = 0;
    exp_q.delete();
  endtask

  // Compare process: checks every output on every falling edge, then
  // advances the model across the coming rising edge.
  always @(negedge clock) begin
    if (!reset_n) begin
      model_reset();
      check("rst_pipe_clear",   int'(bus.pipe_clear),        1);
      check("rst_clock_enable", int'(bus.pipe_clock_enable), 0);
      check("rst_input_ready",  int'(bus.input_ready),       0);
      check("rst_output_valid", int'(bus.output_valid),      0);
      check("rst_drained",      int'(bus.drained),           0);
      check("rst_busy",         int'(bus.busy),              1);
      check("rst_occupancy",    int'(bus.occupancy),         0);
    end else begin
      e_ce   = ((m_mode == M_RUN) || (m_mode == M_DRAIN)) && !bus.flush &&
               ((tag[D-1] == 0) || bus.output_ready);
      e_ir   = e_ce && (m_mode == M_RUN) && !bus.drain_request;
      e_ov   = (tag[D-1] != 0) && !bus.flush && (m_mode != M_FLUSH);
      e_clr  = (m_mode == M_FLUSH);
      e_drn  = (m_mode == M_DRAINED);
      e_occ  = exp_q.size();
      e_busy = (e_occ != 0) || (m_mode != M_RUN);

      check("model_input_ready",  int'(bus.input_ready),       int'(e_ir));
      check("model_output_valid", int'(bus.output_valid),      int'(e_ov));
      check("model_clock_enable", int'(bus.pipe_clock_enable), int'(e_ce));
      check("model_pipe_clear",   int'(bus.pipe_clear),        int'(e_clr));
      check("model_drained",      int'(bus.drained),           int'(e_drn));
      check("model_busy",         int'(bus.busy),              int'(e_busy));
      check("model_occupancy",    int'(bus.occupancy),         e_occ);

      in_hs  = e_ir && bus.input_valid;
      out_hs = e_ov && bus.output_ready;

      nxt_mode = m_mode;
      case (m_mode)
        M_FLUSH:   nxt_mode = M_RUN;
        M_RUN:     if (bus.flush) nxt_mode = M_FLUSH;
                   else if (bus.drain_request) nxt_mode = M_DRAIN;
        M_DRAIN:   if (bus.flush) nxt_mode = M_FLUSH;
                   else if (e_occ == 0) nxt_mode = M_DRAINED;
        default:   if (bus.flush) nxt_mode = M_FLUSH;
                   else if (!bus.drain_request) nxt_mode = M_RUN;
      endcase

      if (m_mode == M_FLUSH) begin
        for (int i = 0; i < D; i++) tag[i] = 0;
        exp_q.delete();
      end else begin
        if (out_hs && exp_q.size() != 0) void'(exp_q.pop_front());
        if (e_ce) begin
          for (int i = D - 1; i > 0; i--) tag[i] = tag[i-1];
          tag[0] = in_hs ? next_id : 0;
          if (in_hs) begin
            exp_q.push_back(16'(next_id));
            next_id++;
          end
        end
      end
      m_mode = nxt_mode;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // ---------------- directed scenarios ----------------
  int outs;

  initial begin
    bus.input_valid   = 1'b0;
    bus.output_ready  = 1'b0;
    bus.flush         = 1'b0;
    bus.drain_request = 1'b0;

    // Reset values while reset is held.
    repeat (3) @(posedge clock);
    #1;
    check("lit_rst_clear", int'(bus.pipe_clear),  1);
    check("lit_rst_busy",  int'(bus.busy),        1);
    check("lit_rst_ready", int'(bus.input_ready), 0);

    // First cycle after release is FLUSH; ready rises the cycle after.
    reset_n = 1'b1;
    #1;
    check("lit_post_rst_clear", int'(bus.pipe_clear),  1);
    check("lit_post_rst_ready", int'(bus.input_ready), 0);
    tick();

    // Stream of 10 words, downstream always ready.
    outs = 0;
    for (int i = 0; i < 15; i++) begin
      drive(i < 10, 1'b1, 1'b0, 1'b0);
      check("lit_stream_ovalid", int'(bus.output_valid), int'(i >= 4 && i < 14));
      if (bus.output_valid) outs++;
      if (i == 0) check("lit_stream_first_ready", int'(bus.input_ready), 1);
      if (i == 4) check("lit_stream_occ_peak", int'(bus.occupancy), 4);
      tick();
    end
    check("lit_stream_count", outs, 10);

    // Backpressure: fill, freeze for 5 cycles, then release.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      check("lit_bp_fill_ready", int'(bus.input_ready), 1);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      check("lit_bp_ready", int'(bus.input_ready),       0);
      check("lit_bp_ce",    int'(bus.pipe_clock_enable), 0);
      check("lit_bp_occ",   int'(bus.occupancy),         4);
      tick();
    end
    outs = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      check("lit_bp_release_ovalid", int'(bus.output_valid), int'(i < 4));
      if (bus.output_valid) outs++;
      tick();
    end
    check("lit_bp_count", outs, 4);

    // Bubbles: alternate valid words and gaps.
    for (int i = 0; i < 14; i++) begin
      drive((i < 8) && (i % 2 == 0), 1'b1, 1'b0, 1'b0);
      check("lit_bubble_ovalid", int'(bus.output_valid),
            int'(i >= 4 && i <= 10 && (i % 2 == 0)));
      check("lit_bubble_occ_le2", int'(bus.occupancy <= 2), 1);
      tick();
    end

    // Flush with 3 words in flight.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    check("lit_flush_req_ready", int'(bus.input_ready), 0);
    check("lit_flush_req_clear", int'(bus.pipe_clear),  0);
    check("lit_flush_req_occ",   int'(bus.occupancy),   3);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    check("lit_flush_clear", int'(bus.pipe_clear),  1);
    check("lit_flush_ready", int'(bus.input_ready), 0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    check("lit_flush_after_ready", int'(bus.input_ready), 1);
    check("lit_flush_after_occ",   int'(bus.occupancy),   0);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      check("lit_flush_no_output", int'(bus.output_valid), 0);
      tick();
    end

    // Drain with 2 words in flight.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    outs = 0;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1);
      check("lit_drain_ready",   int'(bus.input_ready), 0);
      check("lit_drain_drained", int'(bus.drained),     int'(i >= 5));
      if (bus.output_valid) outs++;
      tick();
    end
    check("lit_drain_count", outs, 2);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    check("lit_undrain_drained", int'(bus.drained), 1);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("lit_undrain_ready", int'(bus.input_ready), 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      tick();
    end

    // Simultaneous flush and drain: flush wins, then drain runs on empty pipe.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    check("lit_fd_ready",  int'(bus.input_ready),  0);
    check("lit_fd_ovalid", int'(bus.output_valid), 0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    check("lit_fd_clear", int'(bus.pipe_clear), 1);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    check("lit_fd_run_ready", int'(bus.input_ready), 0);
    check("lit_fd_run_busy",  int'(bus.busy),        0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    check("lit_fd_drain_drained", int'(bus.drained), 0);
    check("lit_fd_drain_busy",    int'(bus.busy),    1);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    check("lit_fd_drained", int'(bus.drained), 1);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    tick();

    // Mid-stream asynchronous reset.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    reset_n = 1'b0;
    #1;
    check("lit_async_clear",  int'(bus.pipe_clear),        1);
    check("lit_async_ce",     int'(bus.pipe_clock_enable), 0);
    check("lit_async_ready",  int'(bus.input_ready),       0);
    check("lit_async_ovalid", int'(bus.output_valid),      0);
    check("lit_async_busy",   int'(bus.busy),              1);
    check("lit_async_occ",    int'(bus.occupancy),         0);
    @(negedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    #1;
    check("lit_rerst_clear", int'(bus.pipe_clear), 1);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(i < 3, 1'b1, 1'b0, 1'b0);
      if (i == 0) check("lit_rerst_ready", int'(bus.input_ready), 1);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
